// File: rtl/dptribus_arb.sv
// rtl/dptribus_arb.sv - round-robin arbiter for a shared tristate datapath bus
// Registered active-low grants, programmable turnaround gap, last-value hold and contention flag.
module dptribus_arb #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 4,
  parameter int TURN  = 1,
  parameter int d_Y_r = 1,
  parameter int d_Y_f = 1
) (
  input  logic                  CLK,
  input  logic                  NRESET,
  input  logic [NSRC-1:0]       REQ_N,
  input  logic [NSRC*WIDTH-1:0] IN,
  output wire  [WIDTH-1:0]      Y,
  output logic [NSRC-1:0]       GNT_N,
  output logic [WIDTH-1:0]      HOLD,
  output logic                  BUSY,
  output logic                  CONTEND
);

  localparam int PW = $clog2(NSRC);
  localparam logic [PW-1:0] LAST_SRC = PW'(NSRC - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_TURN} state_t;

  // d_Y_r/d_Y_f only shape simulation timing of Y in older models; this bus is zero-delay.
  if (NSRC < 2 || NSRC > 16 || TURN < 0 || TURN > 7 || d_Y_r < 0 || d_Y_f < 0) begin : g_param_check
    $error("dptribus_arb: parameter out of range");
  end

  state_t            r_state;
  logic [PW-1:0]     r_ptr;
  logic [2:0]        r_cnt;
  logic [NSRC-1:0]   r_gnt_n;
  logic [WIDTH-1:0]  r_hold;
  logic              r_busy;
  logic              r_contend;

  logic [NSRC-1:0]   w_req;
  logic              w_any;
  logic              w_multi;
  logic              w_found;
  logic [PW-1:0]     w_win;
  logic [PW:0]       w_idx;
  logic [WIDTH-1:0]  w_own;

  // Only a definite 0 counts as a request, so an X on REQ_N never reaches the state.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      w_req[i] = (REQ_N[i] === 1'b0);
    end
  end

  assign w_any   = |w_req;
  assign w_multi = |(w_req & (w_req - NSRC'(1)));

  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    w_idx   = '0;
    for (int k = 1; k <= NSRC; k++) begin
      w_idx = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_idx >= (PW+1)'(NSRC)) begin
        w_idx = w_idx - (PW+1)'(NSRC);
      end
      if (!w_found && w_req[w_idx[PW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[PW-1:0];
      end
    end
  end

  always_comb begin
    w_own = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (r_ptr == PW'(i)) begin
        w_own = IN[i*WIDTH +: WIDTH];
      end
    end
  end

  // The pointer always names the owner while in DRIVE, so a single mux drives the bus.
  assign Y = (r_state == ST_DRIVE) ? w_own : {WIDTH{1'bz}};

  always_ff @(posedge CLK or negedge NRESET) begin
    if (!NRESET) begin
      r_state   <= ST_IDLE;
      r_ptr     <= LAST_SRC;
      r_cnt     <= '0;
      r_gnt_n   <= '1;
      r_hold    <= '0;
      r_busy    <= 1'b0;
      r_contend <= 1'b0;
    end else begin
      r_contend <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gnt_n   <= ~(NSRC'(1) << w_win);
            r_ptr     <= w_win;
            r_busy    <= 1'b1;
            r_contend <= w_multi;
            r_state   <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          r_hold <= w_own;
          if (!w_req[r_ptr]) begin
            r_gnt_n <= '1;
            if (TURN == 0) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_TURN;
              r_cnt   <= 3'(TURN);
            end
          end
        end
        ST_TURN: begin
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt <= 3'd1) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt_n <= '1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign GNT_N   = r_gnt_n;
  assign HOLD    = r_hold;
  assign BUSY    = r_busy;
  assign CONTEND = r_contend;

endmodule
